// File: rtl/brailliance_core.sv
// rtl/brailliance_core.sv - streaming ASCII to 6-dot Grade 1 Braille cell encoder
module brailliance_core #(
    parameter logic [5:0] UNKNOWN_CELL = 6'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] out_cell,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       num_mode
);

    localparam logic [5:0] CAP_SIGN = 6'h20;
    localparam logic [5:0] NUM_SIGN = 6'h3C;

    // Cells for a..j; the rest of the alphabet derives from this decade.
    function automatic logic [5:0] decade_cell(input logic [3:0] idx);
        logic [5:0] c;
        case (idx)
            4'd0:    c = 6'h01;
            4'd1:    c = 6'h03;
            4'd2:    c = 6'h09;
            4'd3:    c = 6'h19;
            4'd4:    c = 6'h11;
            4'd5:    c = 6'h0B;
            4'd6:    c = 6'h1B;
            4'd7:    c = 6'h13;
            4'd8:    c = 6'h0A;
            4'd9:    c = 6'h1A;
            default: c = 6'h00;
        endcase
        return c;
    endfunction

    function automatic logic [5:0] letter_cell(input logic [4:0] idx);
        logic [5:0] c;
        logic [4:0] sub;
        sub = idx - 5'd10;
        if (idx < 5'd10) begin
            c = decade_cell(idx[3:0]);
        end else if (idx < 5'd20) begin
            c = decade_cell(sub[3:0]) | 6'h04;
        end else begin
            case (idx)
                5'd20:   c = 6'h25;
                5'd21:   c = 6'h27;
                5'd22:   c = 6'h3A;
                5'd23:   c = 6'h2D;
                5'd24:   c = 6'h3D;
                5'd25:   c = 6'h35;
                default: c = UNKNOWN_CELL;
            endcase
        end
        return c;
    endfunction

    logic       out_valid_q, out_valid_d;
    logic [5:0] out_cell_q,  out_cell_d;
    logic       pend_q,      pend_d;
    logic [5:0] pend_cell_q, pend_cell_d;
    logic       num_mode_q,  num_mode_d;

    logic       is_upper, is_lower, is_digit;
    logic [4:0] letter_idx, digit_idx;
    logic [5:0] char_cell, prefix_cell;
    logic       has_prefix;
    logic       accept, out_free;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !pend_q && out_free;
    assign accept   = in_valid && in_ready;

    // Upper and lower case share the low five bits, 'a'/'A' mapping to 1.
    always_comb begin
        is_upper    = (in_data >= 8'h41) && (in_data <= 8'h5A);
        is_lower    = (in_data >= 8'h61) && (in_data <= 8'h7A);
        is_digit    = (in_data >= 8'h30) && (in_data <= 8'h39);
        letter_idx  = in_data[4:0] - 5'd1;
        digit_idx   = {1'b0, in_data[3:0]} - 5'd1;
        char_cell   = UNKNOWN_CELL;
        prefix_cell = 6'h00;
        has_prefix  = 1'b0;
        if (is_upper || is_lower) begin
            char_cell = letter_cell(letter_idx);
            if (is_upper) begin
                has_prefix  = 1'b1;
                prefix_cell = CAP_SIGN;
            end
        end else if (is_digit) begin
            char_cell = (in_data == 8'h30) ? 6'h1A : letter_cell(digit_idx);
            if (!num_mode_q) begin
                has_prefix  = 1'b1;
                prefix_cell = NUM_SIGN;
            end
        end else begin
            case (in_data)
                8'h20:   char_cell = 6'h00;
                8'h2C:   char_cell = 6'h02;
                8'h2E:   char_cell = 6'h32;
                8'h3F:   char_cell = 6'h26;
                8'h21:   char_cell = 6'h16;
                default: char_cell = UNKNOWN_CELL;
            endcase
        end
    end

    // Drain and accept never coincide: in_ready is low while a cell is pending.
    always_comb begin
        out_valid_d = out_valid_q;
        out_cell_d  = out_cell_q;
        pend_d      = pend_q;
        pend_cell_d = pend_cell_q;
        num_mode_d  = num_mode_q;
        if (pend_q && out_free) begin
            out_cell_d  = pend_cell_q;
            out_valid_d = 1'b1;
            pend_d      = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            num_mode_d  = is_digit;
            if (has_prefix) begin
                out_cell_d  = prefix_cell;
                pend_d      = 1'b1;
                pend_cell_d = char_cell;
            end else begin
                out_cell_d = char_cell;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_cell_q  <= 6'h00;
            pend_q      <= 1'b0;
            pend_cell_q <= 6'h00;
            num_mode_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_cell_q  <= out_cell_d;
            pend_q      <= pend_d;
            pend_cell_q <= pend_cell_d;
            num_mode_q  <= num_mode_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_cell  = out_cell_q;
    assign num_mode  = num_mode_q;

endmodule

// File: tb/tb_brailliance_core.sv
// tb/tb_brailliance_core.sv - directed self-checking bench for brailliance_core
module tb_brailliance_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] out_cell;
    logic       out_valid;
    logic       out_ready;
    logic       num_mode;

    int vectors     = 0;
    int miscompares = 0;

    logic [5:0] got_q[$];

    brailliance_core #(.UNKNOWN_CELL(6'h3F)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_cell  (out_cell),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .num_mode  (num_mode)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1; a transfer seen here completes on the next posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_cell);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch);
        bit done;
        done     = 1'b0;
        in_data  = ch;
        in_valid = 1'b1;
        for (int b = 0; b < 20 && !done; b++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL send_timeout char=%h in_ready stayed 0", ch);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h61; out_ready = 1'b1;
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++; if (num_mode !== 1'b0) begin miscompares++; $display("FAIL reset_num_mode got=%b exp=0", num_mode); end
        vectors++; if (out_cell !== 6'h00) begin miscompares++; $display("FAIL reset_out_cell got=%h exp=00", out_cell); end
        rst = 1'b0; in_valid = 1'b0;
        got_q.delete();
    endtask

    task automatic test_lowercase();
        logic [7:0] chars [3];
        logic [5:0] exp [3];
        chars = '{8'h61, 8'h62, 8'h7A};
        exp   = '{6'h01, 6'h03, 6'h35};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = chars[i];
            @(negedge clk);
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lower_in_ready[%0d] got=%b exp=1", i, in_ready); end
            if (i > 0) begin
                vectors++;
                if (out_valid !== 1'b1 || out_cell !== exp[i-1]) begin
                    miscompares++; $display("FAIL lower_cell[%0d] got=%h v=%b exp=%h", i-1, out_cell, out_valid, exp[i-1]);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_cell !== exp[2]) begin miscompares++; $display("FAIL lower_cell[2] got=%h v=%b exp=%h", out_cell, out_valid, exp[2]); end
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lower_idle got=%b exp=0", out_valid); end
        got_q.delete();
    endtask

    task automatic test_capital();
        in_data = 8'h4B; in_valid = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL cap_in_ready_pre got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_cell !== 6'h20 || out_valid !== 1'b1) begin miscompares++; $display("FAIL cap_prefix got=%h v=%b exp=20", out_cell, out_valid); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL cap_in_ready_pend got=%b exp=0", in_ready); end
        tick();
        @(negedge clk);
        vectors++; if (out_cell !== 6'h05 || out_valid !== 1'b1) begin miscompares++; $display("FAIL cap_letter got=%h v=%b exp=05", out_cell, out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL cap_in_ready_post got=%b exp=1", in_ready); end
        tick();
        tick();
        got_q.delete();
    endtask

    task automatic test_number_run();
        logic [5:0] exp [6];
        exp = '{6'h3C, 6'h01, 6'h03, 6'h00, 6'h3C, 6'h1A};
        got_q.delete();
        send(8'h31);
        vectors++; if (num_mode !== 1'b1) begin miscompares++; $display("FAIL num_after_1 got=%b exp=1", num_mode); end
        send(8'h32);
        vectors++; if (num_mode !== 1'b1) begin miscompares++; $display("FAIL num_after_2 got=%b exp=1", num_mode); end
        send(8'h20);
        vectors++; if (num_mode !== 1'b0) begin miscompares++; $display("FAIL num_after_space got=%b exp=0", num_mode); end
        send(8'h30);
        vectors++; if (num_mode !== 1'b1) begin miscompares++; $display("FAIL num_after_0 got=%b exp=1", num_mode); end
        repeat (4) tick();
        vectors++; if (got_q.size() != 6) begin miscompares++; $display("FAIL num_count got=%0d exp=6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp[i]) begin miscompares++; $display("FAIL num_cell[%0d] got=%h exp=%h", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_mixed();
        logic [7:0] chars [4];
        logic [5:0] exp [6];
        chars = '{8'h48, 8'h69, 8'h35, 8'h2E};
        exp   = '{6'h20, 6'h13, 6'h0A, 6'h3C, 6'h11, 6'h32};
        got_q.delete();
        for (int i = 0; i < 4; i++) send(chars[i]);
        repeat (3) tick();
        vectors++; if (num_mode !== 1'b0) begin miscompares++; $display("FAIL mixed_num_mode got=%b exp=0", num_mode); end
        vectors++; if (got_q.size() != 6) begin miscompares++; $display("FAIL mixed_count got=%0d exp=6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp[i]) begin miscompares++; $display("FAIL mixed_cell[%0d] got=%h exp=%h", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        got_q.delete();
        send(8'h41);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_cell !== 6'h20 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold[%0d] cell=%h v=%b rdy=%b exp=20/1/0", i, out_cell, out_valid, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        repeat (3) tick();
        vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL bp_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            vectors++; if (got_q[0] !== 6'h20) begin miscompares++; $display("FAIL bp_first got=%h exp=20", got_q[0]); end
            vectors++; if (got_q[1] !== 6'h01) begin miscompares++; $display("FAIL bp_second got=%h exp=01", got_q[1]); end
        end
    endtask

    task automatic test_punctuation();
        logic [7:0] chars [6];
        logic [5:0] exp [6];
        chars = '{8'h23, 8'h2E, 8'h3F, 8'h21, 8'h2C, 8'h7E};
        exp   = '{6'h3F, 6'h32, 6'h26, 6'h16, 6'h02, 6'h3F};
        got_q.delete();
        for (int i = 0; i < 6; i++) send(chars[i]);
        repeat (2) tick();
        vectors++; if (got_q.size() != 6) begin miscompares++; $display("FAIL punct_count got=%0d exp=6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp[i]) begin miscompares++; $display("FAIL punct_cell[%0d] got=%h exp=%h", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_reset_pending();
        out_ready = 1'b0;
        send(8'h51);
        @(negedge clk);
        vectors++; if (out_cell !== 6'h20) begin miscompares++; $display("FAIL rstp_prefix got=%h exp=20", out_cell); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        repeat (5) tick();
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL rstp_emitted got=%0d cells exp=0", got_q.size()); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstp_out_valid got=%b exp=0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstp_in_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        test_reset();
        test_lowercase();
        test_capital();
        test_number_run();
        test_mixed();
        test_backpressure();
        test_punctuation();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/brailliance_core.md
Name: brailliance_core

Overview:
- Streaming ASCII-to-6-dot-Braille (Grade 1 English) encoder; core of the Tiny Tapeout project tt_um_brailliance.
- The tile wrapper drives it from ui_in/uio pins and presents cells on uo_out.
- Accepts one ASCII byte per valid/ready handshake and emits one or two Braille cells per character:
  - an optional capital-sign or number-sign prefix;
  - then the character cell.

Parameters:
- UNKNOWN_CELL, 6'h3F: cell emitted for any unsupported character (all six dots).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  ASCII character.
- in_valid  input  1  in_data valid.
- in_ready  output  1  core can accept in_data this cycle.
- out_cell  output  6  Braille cell; bit0 = dot1 … bit5 = dot6.
- out_valid  output  1  out_cell valid.
- out_ready  input  1  downstream accepts out_cell.
- num_mode  output  1  high while inside a digit run (number sign already sent).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. On a clk edge with rst=1, all of the following clear; no other state is kept:
  - out_valid=0, out_cell=0;
  - pending flag=0, pending cell=0;
  - num_mode=0.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_cell is stable while out_valid=1 and out_ready=0.
- in_ready = !pending && (!out_valid || out_ready). This is combinational from registered state and out_ready.
- Cell mapping (hex, dot bits):
  - a 01, b 03, c 09, d 19, e 11, f 0B, g 1B, h 13, i 0A, j 1A.
  - k–t = a–j cell | 04 (dot3); e.g. k 05, t 1E.
  - u 25, v 27, w 3A, x 2D, y 3D, z 35.
  - Uppercase A–Z: same cell as lowercase.
  - Digits 1–9 → a–i cells; 0 → j cell (1A).
  - Space (20h) → 00; ',' → 02; '.' → 32; '?' → 26; '!' → 16.
  - Anything else → UNKNOWN_CELL.
- Prefixes:
  - Uppercase letter: capital sign 20 (dot6) precedes the letter.
  - Digit with num_mode=0: number sign 3C (dots 3456) precedes the digit; num_mode is set.
  - Digit with num_mode=1: no prefix.
  - Any accepted non-digit clears num_mode, in the same edge as it is accepted.
- On accept, no prefix: out_cell <= cell, out_valid <= 1.
- On accept, with prefix:
  - out_cell <= prefix, out_valid <= 1;
  - pending <= 1, pending cell <= cell.
- Pending drain: when pending && (!out_valid || out_ready):
  - out_cell <= pending cell, out_valid stays 1, pending <= 0.
- Otherwise an output transfer clears out_valid.
- Latency:
  - First cell is valid the cycle after input accept.
  - A prefixed character occupies two output transfers; in_ready is low while pending.
- Throughput: one unprefixed character per cycle with out_ready held high.
- Reset mid-operation: pending and output cells are discarded; nothing is emitted after reset until a new accept.

Test Plan:
- Reset:
  - assert rst with in_valid=1 → out_valid=0, in_ready=1, num_mode=0, out_cell=00 on the next cycle.
- Lowercase stream:
  - "abz" with out_ready=1 → cells 01,03,35 on consecutive cycles; in_ready stays 1.
- Capital:
  - 'K' → cells 20 then 05;
  - in_ready=0 for the cycle the prefix is presented.
- Number run:
  - "12 0" → cells 3C,01,03,00,3C,1A;
  - num_mode 1 after '1', 0 after space, 1 again after '0'.
- Backpressure:
  - send 'A' with out_ready=0 for 5 cycles → out_cell holds 20, in_ready=0;
  - release → 20 transfers, then 01 transfers.
- Unknown/punctuation:
  - '#' → 3F; '.' → 32;
  - rst asserted while 'Q' pending → no 1F cell ever emitted.
